// File: rtl/conv_pkg.sv
// Shared definitions for the convolution operand loader and its compute stage.
package conv_pkg;

  localparam int CONV_DATA_W = 8;
  localparam int CONV_N_WGT  = 9;
  localparam int CONV_N_ACT  = 16;

  typedef enum logic [1:0] {
    LOAD_W = 2'd0,
    LOAD_A = 2'd1,
    RUN    = 2'd2
  } loader_state_t;

endpackage

// File: rtl/operand_regfile.sv
// Indexed write-enable register bank with a flattened read bus; entry 0 sits
// in the least significant DATA_W bits.
module operand_regfile #(
  parameter int DEPTH  = 9,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IDX_W-1:0]        idx,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DEPTH*DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Per-entry write decode; an index beyond DEPTH matches no entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we && (idx == IDX_W'(i))) mem[i] <= wdata;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_rd
    assign rdata[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: rtl/conv_operand_loader.sv
// Operand loader feeding the single-PE 3x3/4x4 convolution stage.
// Captures 9 filter bytes then 16 activation bytes, holds them stable while
// active_single is high, and waits for done_single before the next frame.
// Optional build macro CONV_LOADER_WEIGHT_REUSE_EN adds the wgt_keep port so a
// loaded filter can be reused and only activations are streamed.
//
// state  | meaning
// LOAD_W | accepting filter bytes b11..b33
// LOAD_A | accepting activation bytes a11..a44
// RUN    | operands frozen, compute stage enabled, waiting for done_single
module conv_operand_loader
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic [CONV_N_WGT*DATA_W-1:0] wgt_o,
  output logic [CONV_N_ACT*DATA_W-1:0] act_o,
  output logic                         active_single,
  input  logic                         done_single,
`ifdef CONV_LOADER_WEIGHT_REUSE_EN
  input  logic                         wgt_keep,
`endif
  output logic                         busy,
  output logic [15:0]                  frame_cnt
);

  loader_state_t state;
  logic [3:0]    cnt;
  logic          xfer;
  logic          wgt_we;
  logic          act_we;
`ifdef CONV_LOADER_WEIGHT_REUSE_EN
  logic          wgt_loaded;
`endif

  // in_ready is a registered decode of state, so it is safe to gate with it.
  assign xfer   = in_valid && in_ready;
  assign wgt_we = xfer && (state == LOAD_W);
  assign act_we = xfer && (state == LOAD_A);
  assign busy   = !((state == LOAD_W) && (cnt == 4'd0));

  operand_regfile #(.DEPTH(CONV_N_WGT), .DATA_W(DATA_W), .IDX_W(4)) u_wgt (
    .clk   (clk),
    .rst   (rst),
    .we    (wgt_we),
    .idx   (cnt),
    .wdata (in_data),
    .rdata (wgt_o)
  );

  operand_regfile #(.DEPTH(CONV_N_ACT), .DATA_W(DATA_W), .IDX_W(4)) u_act (
    .clk   (clk),
    .rst   (rst),
    .we    (act_we),
    .idx   (cnt),
    .wdata (in_data),
    .rdata (act_o)
  );

  // Frame sequencing FSM with registered handshake and run-enable outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LOAD_W;
      cnt           <= 4'd0;
      in_ready      <= 1'b1;
      active_single <= 1'b0;
      frame_cnt     <= 16'd0;
`ifdef CONV_LOADER_WEIGHT_REUSE_EN
      wgt_loaded    <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD_W: begin
          if (xfer) begin
            if (cnt == 4'(CONV_N_WGT - 1)) begin
              cnt   <= 4'd0;
              state <= LOAD_A;
`ifdef CONV_LOADER_WEIGHT_REUSE_EN
              wgt_loaded <= 1'b1;
`endif
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        LOAD_A: begin
          if (xfer) begin
            if (cnt == 4'(CONV_N_ACT - 1)) begin
              cnt           <= 4'd0;
              state         <= RUN;
              in_ready      <= 1'b0;
              active_single <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        RUN: begin
          if (done_single) begin
            cnt           <= 4'd0;
            in_ready      <= 1'b1;
            active_single <= 1'b0;
            frame_cnt     <= frame_cnt + 16'd1;
`ifdef CONV_LOADER_WEIGHT_REUSE_EN
            state <= (wgt_keep && wgt_loaded) ? LOAD_A : LOAD_W;
`else
            state <= LOAD_W;
`endif
          end
        end
        default: begin
          state         <= LOAD_W;
          cnt           <= 4'd0;
          in_ready      <= 1'b1;
          active_single <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_operand_loader.sv
// Directed bench for conv_operand_loader with an expected-operand scoreboard
// and a behavioural compute stage that raises done_single in its 38th
// active cycle.
module tb_conv_operand_loader;
  import conv_pkg::*;

  localparam int W = CONV_DATA_W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_data;
  logic [CONV_N_WGT*W-1:0] wgt_o;
  logic [CONV_N_ACT*W-1:0] act_o;
  logic                  active_single;
  logic                  done_single;
  logic                  busy;
  logic [15:0]           frame_cnt;
`ifdef CONV_LOADER_WEIGHT_REUSE_EN
  logic                  wgt_keep;
`endif

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;
  int run_cnt;
  logic force_done;
  logic [7:0] fb [25];
  logic [CONV_N_WGT*W-1:0] last_wgt;
  logic [CONV_N_WGT*W-1:0] wgt_q [$];
  logic [CONV_N_ACT*W-1:0] act_q [$];

  conv_operand_loader #(.DATA_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .wgt_o         (wgt_o),
    .act_o         (act_o),
    .active_single (active_single),
    .done_single   (done_single),
`ifdef CONV_LOADER_WEIGHT_REUSE_EN
    .wgt_keep      (wgt_keep),
`endif
    .busy          (busy),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  // Compute-stage stand-in: counts active cycles, done in the 38th.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_cnt <= 0;
    else if (active_single) run_cnt <= run_cnt + 1;
    else run_cnt <= 0;
  end
  assign done_single = (active_single && (run_cnt == 37)) || force_done;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int conv(input logic [71:0] w, input logic [127:0] a, input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(w[(i*3+j)*8 +: 8]) * int'(a[((r+i)*4 + c + j)*8 +: 8]);
    return s;
  endfunction

  task automatic push_frame(input bit reuse);
    logic [CONV_N_WGT*W-1:0] w;
    logic [CONV_N_ACT*W-1:0] a;
    if (reuse) w = last_wgt;
    else for (int i = 0; i < 9; i++) w[i*8 +: 8] = fb[i];
    for (int i = 0; i < 16; i++) a[i*8 +: 8] = fb[9+i];
    last_wgt = w;
    wgt_q.push_back(w);
    act_q.push_back(a);
  endtask

  task automatic send(input logic [7:0] d, input bit toggle, inout int cyc);
    int n;
    bit rdy;
    if (toggle) begin
      in_valid = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      rdy = in_ready;
      @(posedge clk); #1; cyc++; n++;
    end while (!rdy && n < 100);
    if (!rdy) check("send_timeout_ready", 128'(rdy), 128'(1));
  endtask

  // Streams fb[first .. first+n-1]; the last transfer must start the run.
  task automatic stream(input int first, input int n, input bit toggle, output int cyc);
    logic [CONV_N_WGT*W-1:0] ew;
    logic [CONV_N_ACT*W-1:0] ea;
    cyc = 0;
    for (int i = first; i < first + n; i++) begin
      if (i == first + n - 1) check("active_before_last", 128'(active_single), 128'(0));
      send(fb[i], toggle, cyc);
    end
    in_valid = 1'b0;
    check("active_at_last", 128'(active_single), 128'(1));
    check("ready_in_run", 128'(in_ready), 128'(0));
    ew = wgt_q.pop_front();
    ea = act_q.pop_front();
    check("wgt_o", 128'(wgt_o), 128'(ew));
    check("act_o", 128'(act_o), 128'(ea));
  endtask

  task automatic finish_run(input bit exp_busy);
    int n = 0;
    bit bad = 0;
    while (!in_ready && n < 200) begin
      if (!active_single) bad = 1;
      @(posedge clk); #1; n++;
    end
    exp_frames++;
    check("run_len", 128'(n), 128'(38));
    check("active_held", 128'(bad), 128'(0));
    check("ready_after_done", 128'(in_ready), 128'(1));
    check("active_after_done", 128'(active_single), 128'(0));
    check("frame_cnt", 128'(frame_cnt), 128'(exp_frames));
    check("busy_after_done", 128'(busy), 128'(exp_busy));
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_active", 128'(active_single), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_wgt", 128'(wgt_o), 128'(0));
    check("rst_act", 128'(act_o), 128'(0));
    check("rst_frame_cnt", 128'(frame_cnt), 128'(0));
  endtask

  initial begin
    int cyc;
    int dummy;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; force_done = 1'b0;
`ifdef CONV_LOADER_WEIGHT_REUSE_EN
    wgt_keep = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame 1: bytes 1..25, continuous
    for (int i = 0; i < 25; i++) fb[i] = 8'(i + 1);
    push_frame(1'b0);
    stream(0, 25, 1'b0, cyc);
    check("cont_cycles", 128'(cyc), 128'(25));
    finish_run(1'b0);

    // Frame 2: all-ones operands, every 2x2 output is 9
    for (int i = 0; i < 25; i++) fb[i] = 8'd1;
    push_frame(1'b0);
    stream(0, 25, 1'b0, cyc);
    check("c11", 128'(conv(wgt_o, act_o, 0, 0)), 128'(9));
    check("c12", 128'(conv(wgt_o, act_o, 0, 1)), 128'(9));
    check("c21", 128'(conv(wgt_o, act_o, 1, 0)), 128'(9));
    check("c22", 128'(conv(wgt_o, act_o, 1, 1)), 128'(9));
    finish_run(1'b0);

    // Frame 3: in_valid toggling, 25 transfers in 50 cycles
    for (int i = 0; i < 25; i++) fb[i] = 8'(i + 1);
    push_frame(1'b0);
    stream(0, 25, 1'b1, cyc);
    check("toggle_cycles", 128'(cyc), 128'(50));
    finish_run(1'b0);

    // Reset at the 12th activation transfer discards the partial frame
    for (int i = 0; i < 25; i++) fb[i] = 8'(8'h40 + i);
    push_frame(1'b0);
    dummy = 0;
    for (int i = 0; i < 21; i++) send(fb[i], 1'b0, dummy);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_vals();
    void'(wgt_q.pop_back());
    void'(act_q.pop_back());
    exp_frames = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fresh frame after the abort
    for (int i = 0; i < 25; i++) fb[i] = 8'(8'h60 + i);
    push_frame(1'b0);
    stream(0, 25, 1'b0, cyc);
    finish_run(1'b0);

    // done_single pulsed while stalled in LOAD_A is ignored
    for (int i = 0; i < 25; i++) fb[i] = 8'(8'h80 + i);
    push_frame(1'b0);
    dummy = 0;
    for (int i = 0; i < 9; i++) send(fb[i], 1'b0, dummy);
    in_valid = 1'b0;
    @(posedge clk); #1;
    force_done = 1'b1;
    @(posedge clk); #1;
    force_done = 1'b0;
    check("ign_done_frame_cnt", 128'(frame_cnt), 128'(exp_frames));
    check("ign_done_ready", 128'(in_ready), 128'(1));
    check("ign_done_active", 128'(active_single), 128'(0));
    check("ign_done_busy", 128'(busy), 128'(1));
    stream(9, 16, 1'b0, cyc);
`ifdef CONV_LOADER_WEIGHT_REUSE_EN
    wgt_keep = 1'b1;
    finish_run(1'b1);
    wgt_keep = 1'b0;

    // Weight reuse: only 16 activation bytes 0xA0..0xAF
    for (int i = 0; i < 16; i++) fb[9+i] = 8'(8'hA0 + i);
    push_frame(1'b1);
    stream(9, 16, 1'b0, cyc);
    check("reuse_cycles", 128'(cyc), 128'(16));
    finish_run(1'b0);
`else
    finish_run(1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_operand_loader.md
# conv_operand_loader

Upstream feeder for `single_process_array`, the single-PE 3x3-filter / 4x4-input convolution stage. It accepts a byte stream over a valid/ready handshake and captures 9 filter bytes and 16 activation bytes into a register file. It holds those operands stable, asserts `active_single` for the whole compute run and waits for `done_single`. Only then does it accept the next frame.

## Interface
Parameters:
- `DATA_W`, 8: width of one operand byte; must match the compute stage.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset; asynchronous, active-high.
- `in_valid`, input, 1: `in_data` carries a byte.
- `in_ready`, output, 1: loader accepts a byte this cycle.
- `in_data`, input, `DATA_W`: operand byte.
- `wgt_o`, output, 9*`DATA_W`: filter b11..b33, row-major; b11 in bits [`DATA_W`-1:0].
- `act_o`, output, 16*`DATA_W`: activations a11..a44, row-major; a11 in bits [`DATA_W`-1:0].
- `active_single`, output, 1: run enable to the compute stage.
- `done_single`, input, 1: compute-stage completion; one-cycle, combinational from its last state.
- `busy`, output, 1: high in every state other than `LOAD_W` with count 0.
- `frame_cnt`, output, 16: number of completed frames; wraps at 65535 to 0.
- `wgt_keep`, input, 1: present only with `WEIGHT_REUSE_EN`.

## Operation
- A transfer occurs at a posedge when `in_valid` and `in_ready` are both high.
- Frame order: 9 filter bytes b11,b12,b13,b21,…,b33, then 16 activation bytes a11,…,a44.
- FSM states:
  - `LOAD_W`: `in_ready`=1. Each transfer writes `wgt[cnt]` and increments `cnt`. On the transfer with `cnt`=8, `cnt` returns to 0 and the FSM goes to `LOAD_A`.
  - `LOAD_A`: `in_ready`=1. Each transfer writes `act[cnt]`. On the transfer with `cnt`=15, `cnt` returns to 0 and the FSM goes to `RUN`.
  - `RUN`: `in_ready`=0 and `active_single`=1. `wgt_o` and `act_o` are frozen. When `done_single`=1 at a posedge, `frame_cnt` increments and the FSM goes to `LOAD_W`.
- `cnt` is 4 bits and is reset to 0 on every state change.
- `in_valid` low in a load state stalls that state; there is no timeout.
- `done_single` is ignored outside `RUN`.
- Register contents are never cleared between frames, only overwritten.

## Timing
- Reset values:
  - state `LOAD_W`, `cnt`=0.
  - `in_ready`=1, `active_single`=0, `busy`=0.
  - `wgt_o`=0, `act_o`=0, `frame_cnt`=0.
  - `rst` asserted mid-load or mid-run aborts immediately to these values. The partial frame is discarded.
- `in_ready` and `active_single` are registered state decodes, not functions of `in_valid`.
- Last activation accepted at edge T: `active_single`=1 from T; the compute stage sees S0 operands in cycle T..T+1.
- The compute stage raises `done_single` in its 38th active cycle. At that edge `active_single` falls and `in_ready` rises, in the same edge as the compute stage returns to S0.
- Minimum frame period: 25 load cycles + 38 run cycles = 63 cycles. With weight reuse it is 16 + 38 = 54.
- `done_single` and reset asserted together: reset wins, and `frame_cnt` does not increment.

## Configuration
- Macro: `CONV_LOADER_WEIGHT_REUSE_EN`.
- When defined:
  - Port `wgt_keep` exists. It is sampled at the `RUN` exit edge.
  - If `wgt_keep`=1 and a filter has been loaded since reset (internal flag `wgt_loaded`), the next state is `LOAD_A`. The frame then contains 16 activation bytes only, and `wgt_o` is retained.
  - Otherwise the next state is `LOAD_W`.
  - `wgt_loaded` is set on entry to `LOAD_A` from `LOAD_W` and is cleared by reset.
- When undefined: there is no port, and `RUN` always exits to `LOAD_W`.

## Structure
- Shared package `conv_pkg`:
  - Constants `CONV_DATA_W`=8, `CONV_N_WGT`=9, `CONV_N_ACT`=16.
  - Enum `loader_state_t` {`LOAD_W`, `LOAD_A`, `RUN`}, 2 bits.
- One sub-module, `operand_regfile`: an indexed write-enable register bank, instantiated twice, with depth 9 and depth 16. It exposes a flattened read bus.
- The FSM and counters live in the top level.

## Test plan
- Reset then stream bytes 1..25 with `in_valid` continuous:
  - `wgt_o` bytes = 1..9 and `act_o` bytes = 10..25.
  - `active_single` rises exactly at the 25th transfer edge.
  - `in_ready`=0 until `done_single`.
- Model `done_single` 38 cycles after `active_single` rises, with an attached `single_process_array` and all-ones operands:
  - `c11` = 9; `c12`, `c21`, `c22` each also = 9 (all-ones 3x3 window).
  - `frame_cnt`=1 and `in_ready`=1 on the cycle after done.
- `in_valid` toggling every other cycle: 25 transfers take 50 cycles; operands are identical to the continuous case.
- Assert `rst` at the 12th activation transfer: all outputs return to their reset values. A fresh 25-byte frame then loads correctly.
- With `CONV_LOADER_WEIGHT_REUSE_EN` and `wgt_keep`=1 after frame 1, stream 16 bytes 0xA0..0xAF:
  - `active_single` rises after the 16th transfer.
  - `wgt_o` is unchanged and `act_o` holds 0xA0..0xAF.
- Pulse `done_single` while in `LOAD_A`: it is ignored, with no state change and no `frame_cnt` increment.
